// File: rtl/decodificador_varredura.sv
// -----------------------------------------------------------------------------
// decodificador_varredura
//
// Registered one-of-N channel selector. It has two modes:
//   - manual: the channel index comes from Selecao.
//   - automatic scan: the index rotates through 0..N_SAIDAS-1 and holds each
//     value for DIVISOR enabled cycles.
// Typical uses are digit/row enables for multiplexed displays and similar
// strobes. It also outputs the current index and a change pulse, which drive
// the datapath mux that feeds the active channel.
//
// Parameters:
//   N_SAIDAS  number of one-hot outputs, 2..16 (need not be a power of two)
//   DIVISOR   dwell per channel in scan mode, in enabled cycles (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   Habilita  update/advance enable; when low all state holds
//   Modo      0 = manual (Selecao), 1 = automatic scan
//   Selecao   requested channel in manual mode (out-of-range values ignored)
//   Saida     registered one-hot channel enable
//   Indice    registered current channel number
//   Troca     one-cycle pulse, high in the cycle after Indice changed
//
// Optional build macro DECOD_BLANKING_EN:
//   When this macro is defined, every index change blanks Saida (all zeros) for
//   one cycle before the new one-hot appears. This prevents ghosting.
//   Requires DIVISOR >= 2.
// -----------------------------------------------------------------------------
module decodificador_varredura #(
    parameter int N_SAIDAS = 4,
    parameter int DIVISOR  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Habilita,
    input  logic                        Modo,
    input  logic [$clog2(N_SAIDAS)-1:0] Selecao,
    output logic [N_SAIDAS-1:0]         Saida,
    output logic [$clog2(N_SAIDAS)-1:0] Indice,
    output logic                        Troca
);

    localparam int SEL_W = $clog2(N_SAIDAS);
    // One spare bit so that DIVISOR-1 always fits without aliasing.
    localparam int CNT_W = $clog2(DIVISOR) + 1;

    localparam logic [SEL_W:0]   N_LIMITE        = (SEL_W+1)'(N_SAIDAS);
    localparam logic [SEL_W-1:0] ULTIMO_INDICE   = SEL_W'(N_SAIDAS - 1);
    localparam logic [CNT_W-1:0] ULTIMA_CONTAGEM = CNT_W'(DIVISOR - 1);

    // Elaboration-time parameter checks
    if (N_SAIDAS < 2 || N_SAIDAS > 16) begin : g_chk_n_saidas
        $error("decodificador_varredura: N_SAIDAS must be in 2..16");
    end
`ifdef DECOD_BLANKING_EN
    if (DIVISOR < 2) begin : g_chk_divisor
        $error("decodificador_varredura: blanking requires DIVISOR >= 2");
    end
`else
    if (DIVISOR < 1) begin : g_chk_divisor
        $error("decodificador_varredura: DIVISOR must be >= 1");
    end
`endif

    logic [CNT_W-1:0] contador;
    logic [CNT_W-1:0] prox_contador;
    logic [SEL_W-1:0] prox_indice;
    logic             muda;

    // Decodes an index into a one-hot vector. Only positions < N_SAIDAS exist.
    function automatic logic [N_SAIDAS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_SAIDAS-1:0] v;
        v = '0;
        for (int i = 0; i < N_SAIDAS; i++) begin
            v[i] = (idx == SEL_W'(i));
        end
        return v;
    endfunction

    // Next-state computation. The outputs themselves are all registered below.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
        prox_indice   = Indice;
        prox_contador = contador;
        if (Habilita) begin
            if (!Modo) begin
                prox_contador = '0;
                // Out-of-range requests are ignored: the index simply holds.
                if ({1'b0, Selecao} < N_LIMITE) begin
                    prox_indice = Selecao;
                end
            end else if (contador == ULTIMA_CONTAGEM) begin
                prox_contador = '0;
                // Wrap at N_SAIDAS, not at 2**SEL_W, for non-power-of-two sizes.
                prox_indice   = (Indice == ULTIMO_INDICE) ? '0 : Indice + SEL_W'(1);
            end else begin
                prox_contador = contador + CNT_W'(1);
            end
        end
    end

    // When Habilita is low, prox_indice equals Indice, so muda (and Troca) stay low.
    assign muda = (prox_indice != Indice);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            contador <= '0;
            Indice   <= '0;
            Saida    <= N_SAIDAS'(1);
            Troca    <= 1'b0;
        end else begin
            contador <= prox_contador;
            Indice   <= prox_indice;
            Troca    <= muda;
`ifdef DECOD_BLANKING_EN
            // Blank for one cycle on every change. A held (non-changing) edge
            // always restores onehot(Indice), which ends any pending blank.
            Saida    <= muda ? '0 : onehot(prox_indice);
`else
            Saida    <= onehot(prox_indice);
`endif
        end
    end

endmodule

// File: tb/tb_decodificador_varredura.sv
module tb_decodificador_varredura;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       hab;
    logic       modo;
    logic [2:0] sel;

    // DUT A: N_SAIDAS=4, DIVISOR=4
    logic [3:0] saida_a;
    logic [1:0] idx_a;
    logic       troca_a;
    // DUT B: N_SAIDAS=5, DIVISOR=1
    logic [4:0] saida_b;
    logic [2:0] idx_b;
    logic       troca_b;
    // DUT C: N_SAIDAS=5, DIVISOR=2
    logic [4:0] saida_c;
    logic [2:0] idx_c;
    logic       troca_c;

    decodificador_varredura #(.N_SAIDAS(4), .DIVISOR(4)) dut_a (
        .clk(clk), .reset(reset), .Habilita(hab), .Modo(modo), .Selecao(sel[1:0]),
        .Saida(saida_a), .Indice(idx_a), .Troca(troca_a)
    );
    decodificador_varredura #(.N_SAIDAS(5), .DIVISOR(1)) dut_b (
        .clk(clk), .reset(reset), .Habilita(hab), .Modo(modo), .Selecao(sel),
        .Saida(saida_b), .Indice(idx_b), .Troca(troca_b)
    );
    decodificador_varredura #(.N_SAIDAS(5), .DIVISOR(2)) dut_c (
        .clk(clk), .reset(reset), .Habilita(hab), .Modo(modo), .Selecao(sel),
        .Saida(saida_c), .Indice(idx_c), .Troca(troca_c)
    );

    typedef struct {
        int         alvo;
        int         linha;
        logic [2:0] idx;
        logic [4:0] saida;
        logic       troca;
    } esperado_t;

    esperado_t fila[$];
    int  n_cmp  = 0;
    int  n_err  = 0;
    int  n_vec  = 0;
    bit  armado = 1'b0;

    task automatic check(input string nome, input int linha,
                         input logic [7:0] atual, input logic [7:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nome, linha, atual, esperado);
        end
    endtask

    // Drive one vector, let one edge elapse, then queue the expected result.
    task automatic vec(input int alvo, input logic r, input logic h, input logic m,
                       input logic [2:0] s, input logic [2:0] i, input logic t);
        esperado_t e;
        reset = r;
        hab   = h;
        modo  = m;
        sel   = s;
        @(posedge clk);
        e.alvo  = alvo;
        e.linha = n_vec;
        e.idx   = i;
        e.saida = 5'b00001 << i;
        e.troca = t;
        fila.push_back(e);
        n_vec++;
        #1;
    endtask

    // Monitor: each cycle, pop one expectation and compare it with the selected DUT.
    esperado_t  m_e;
    logic [7:0] m_idx;
    logic [7:0] m_saida;
    logic [7:0] m_troca;
    always @(negedge clk) begin
        if (armado) begin
            check("onehot_a", n_vec, 8'($countones(saida_a)), 8'd1);
            check("onehot_b", n_vec, 8'($countones(saida_b)), 8'd1);
            check("onehot_c", n_vec, 8'($countones(saida_c)), 8'd1);
        end
        if (fila.size() > 0) begin
            m_e = fila.pop_front();
            case (m_e.alvo)
                0: begin
                    m_idx = {6'd0, idx_a}; m_saida = {4'd0, saida_a}; m_troca = {7'd0, troca_a};
                end
                1: begin
                    m_idx = {5'd0, idx_b}; m_saida = {3'd0, saida_b}; m_troca = {7'd0, troca_b};
                end
                default: begin
                    m_idx = {5'd0, idx_c}; m_saida = {3'd0, saida_c}; m_troca = {7'd0, troca_c};
                end
            endcase
            check("indice", m_e.linha, m_idx,   {5'd0, m_e.idx});
            check("saida",  m_e.linha, m_saida, {3'd0, m_e.saida});
            check("troca",  m_e.linha, m_troca, {7'd0, m_e.troca});
        end
    end

    initial begin
        reset = 1'b1;
        hab   = 1'b0;
        modo  = 1'b0;
        sel   = 3'd0;

        // ---- DUT A (N=4, DIVISOR=4): reset, scan, reset mid-dwell, full scan ----
        vec(0, 1, 1, 1, 3'd0, 3'd0, 0);
        armado = 1'b1;
        for (int k = 1; k <= 11; k++) vec(0, 0, 1, 1, 3'd0, 3'(k / 4), (k % 4) == 0);
        // Indice is now 2 with counter 3. Reset must clear both.
        vec(0, 1, 1, 1, 3'd0, 3'd0, 0);
        // First advance comes exactly 4 enabled edges later, then a full period with wrap.
        for (int k = 1; k <= 16; k++) vec(0, 0, 1, 1, 3'd0, 3'((k / 4) % 4), (k % 4) == 0);
        // Manual -> scan: scanning resumes from 2 with a fresh dwell.
        vec(0, 0, 1, 0, 3'd2, 3'd2, 1);
        for (int k = 0; k < 3; k++) vec(0, 0, 1, 1, 3'd0, 3'd2, 0);
        vec(0, 0, 1, 1, 3'd0, 3'd3, 1);
        // Scan -> manual: a valid Selecao is taken immediately. A repeat gives no pulse.
        vec(0, 0, 1, 0, 3'd1, 3'd1, 1);
        vec(0, 0, 1, 0, 3'd1, 3'd1, 0);

        // ---- DUT B (N=5, DIVISOR=1): non-power-of-two wrap, manual range ----
        vec(1, 1, 1, 1, 3'd0, 3'd0, 0);
        for (int k = 1; k <= 6; k++) vec(1, 0, 1, 1, 3'd0, 3'(k % 5), 1);
        vec(1, 0, 1, 0, 3'd3, 3'd3, 1);   // Selecao=3
        vec(1, 0, 1, 0, 3'd6, 3'd3, 0);   // out of range: hold, no pulse
        vec(1, 0, 1, 0, 3'd3, 3'd3, 0);   // same value: no pulse
        vec(1, 0, 1, 0, 3'd5, 3'd3, 0);   // first illegal value
        vec(1, 0, 1, 0, 3'd7, 3'd3, 0);
        vec(1, 0, 1, 0, 3'd4, 3'd4, 1);   // last legal value
        vec(1, 0, 1, 0, 3'd0, 3'd0, 1);
        vec(1, 0, 0, 0, 3'd2, 3'd0, 0);   // disabled: Selecao ignored

        // ---- DUT C (N=5, DIVISOR=2): Habilita gating mid-dwell ----
        vec(2, 1, 1, 1, 3'd0, 3'd0, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd0, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd1, 1);
        vec(2, 0, 1, 1, 3'd0, 3'd1, 0);   // mid-dwell, counter=1
        for (int k = 0; k < 5; k++) vec(2, 0, 0, 1, 3'd0, 3'd1, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd2, 1);   // remaining dwell was one cycle
        vec(2, 0, 1, 1, 3'd0, 3'd2, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd3, 1);
        for (int k = 0; k < 2; k++) vec(2, 0, 0, 1, 3'd0, 3'd3, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd3, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd4, 1);
        vec(2, 0, 1, 1, 3'd0, 3'd4, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd0, 1);   // wrap 4 -> 0
        vec(2, 0, 1, 1, 3'd0, 3'd0, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd1, 1);
        vec(2, 1, 0, 1, 3'd0, 3'd0, 0);   // reset overrides Habilita=0
        vec(2, 0, 1, 1, 3'd0, 3'd0, 0);
        vec(2, 0, 1, 1, 3'd0, 3'd1, 1);

        @(negedge clk);
        #1;
        if (fila.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", fila.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
